// File: rtl/i2s_frame_receiver.sv
// i2s_frame_receiver: oversampled I2S pin front-end that aligns slots
// from WS transitions and presents per-channel samples on valid/ready.
module i2s_frame_receiver #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i2s_bclk,
  input  logic                    i2s_ws,
  input  logic                    i2s_sd,
  input  logic                    sample_ready,
  output logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    sample_right,
  output logic                    sample_valid,
  output logic                    locked,
  output logic                    frame_error,
  output logic                    overrun
);

  localparam int IW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_SAMPLE = IW'(SAMPLE_WIDTH - 1);
  localparam logic [IW-1:0] LAST_SLOT   = IW'(SLOT_WIDTH - 1);

  typedef enum logic [1:0] {
    UNLOCKED,
    SHIFT,
    SKIP
  } state_t;

  logic [SYNC_STAGES-1:0]  bclk_sync_q;
  logic [SYNC_STAGES-1:0]  ws_sync_q;
  logic [SYNC_STAGES-1:0]  sd_sync_q;
  logic                    bclk_prev_q;
  logic                    bclk_s, ws_s, sd_s;
  logic                    rise, ws_edge;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    chan_q, chan_d;
  logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d;
  logic                    ws_prev_q, ws_prev_d;
  logic                    ws_seen_q, ws_seen_d;
  logic                    complete;

  logic [SAMPLE_WIDTH-1:0] data_q, data_d;
  logic                    right_q, right_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;
  logic                    ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q <= '0;
      ws_sync_q   <= '0;
      sd_sync_q   <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
      ws_sync_q   <= {ws_sync_q[SYNC_STAGES-2:0], i2s_ws};
      sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], i2s_sd};
      bclk_prev_q <= bclk_s;
    end
  end

  assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
  assign ws_s   = ws_sync_q[SYNC_STAGES-1];
  assign sd_s   = sd_sync_q[SYNC_STAGES-1];
  assign rise   = bclk_s & ~bclk_prev_q;
  // No edge until one WS value has been captured since reset.
  assign ws_edge = rise & ws_seen_q & (ws_s ^ ws_prev_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    chan_d    = chan_q;
    shreg_d   = shreg_q;
    ws_prev_d = ws_prev_q;
    ws_seen_d = ws_seen_q;
    complete  = 1'b0;
    ferr_d    = 1'b0;
    if (rise) begin
      ws_prev_d = ws_s;
      ws_seen_d = 1'b1;
      unique case (state_q)
        UNLOCKED: begin
          if (ws_edge) begin
            state_d = SHIFT;
            idx_d   = '0;
            chan_d  = ws_s;
          end
        end
        SHIFT: begin
          shreg_d  = {shreg_q[SAMPLE_WIDTH-2:0], sd_s};
          complete = (idx_q == LAST_SAMPLE);
          if (ws_edge) begin
            ferr_d = ~complete;
            idx_d  = '0;
            chan_d = ws_s;
          end else begin
            idx_d = idx_q + 1'b1;
            if (complete) state_d = SKIP;
          end
        end
        SKIP: begin
          if (ws_edge) begin
            state_d = SHIFT;
            idx_d   = '0;
            chan_d  = ws_s;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = UNLOCKED;
      endcase
      // Slot overran its maximum length without a WS transition.
      if (state_q != UNLOCKED && !ws_edge && idx_q == LAST_SLOT) begin
        ferr_d  = 1'b1;
        state_d = UNLOCKED;
        idx_d   = '0;
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    right_d = right_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && sample_ready) valid_d = 1'b0;
    if (complete) begin
      if (!valid_q || sample_ready) begin
        data_d  = shreg_d;
        right_d = chan_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= UNLOCKED;
      idx_q     <= '0;
      chan_q    <= 1'b0;
      shreg_q   <= '0;
      ws_prev_q <= 1'b0;
      ws_seen_q <= 1'b0;
      data_q    <= '0;
      right_q   <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      chan_q    <= chan_d;
      shreg_q   <= shreg_d;
      ws_prev_q <= ws_prev_d;
      ws_seen_q <= ws_seen_d;
      data_q    <= data_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign locked       = (state_q != UNLOCKED);
  assign frame_error  = ferr_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_i2s_frame_receiver.sv
// tb_i2s_frame_receiver: directed and randomized I2S streams checked
// against a slot-level model, on 32-bit and 24-bit slot builds.
module tb_i2s_frame_receiver;

  localparam int SW = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bclk = 1'b0;
  logic ws = 1'b0;
  logic sd = 1'b0;
  logic ready = 1'b1;

  logic [SW-1:0] d32, d24;
  logic r32, v32, l32, fe32, ov32;
  logic r24, v24, l24, fe24, ov24;

  always #5 clk = ~clk;

  i2s_frame_receiver #(
    .SAMPLE_WIDTH(SW), .SLOT_WIDTH(32), .SYNC_STAGES(2)
  ) u_dut (
    .clk(clk), .reset(reset),
    .i2s_bclk(bclk), .i2s_ws(ws), .i2s_sd(sd),
    .sample_ready(ready),
    .sample_data(d32), .sample_right(r32),
    .sample_valid(v32), .locked(l32),
    .frame_error(fe32), .overrun(ov32)
  );

  i2s_frame_receiver #(
    .SAMPLE_WIDTH(SW), .SLOT_WIDTH(24), .SYNC_STAGES(2)
  ) u_dut24 (
    .clk(clk), .reset(reset),
    .i2s_bclk(bclk), .i2s_ws(ws), .i2s_sd(sd),
    .sample_ready(ready),
    .sample_data(d24), .sample_right(r24),
    .sample_valid(v24), .locked(l24),
    .frame_error(fe24), .overrun(ov24)
  );

  int checks = 0;
  int errors = 0;

  logic [SW:0] cap32 [0:511];
  logic [SW:0] cap24 [0:511];
  int n32 = 0, nfe32 = 0, nov32 = 0;
  int n24 = 0, nfe24 = 0, nov24 = 0;

  always @(negedge clk) begin
    if (v32 && ready) begin
      if (n32 < 512) cap32[n32] = {r32, d32};
      n32++;
    end
    if (v24 && ready) begin
      if (n24 < 512) cap24[n24] = {r24, d24};
      n24++;
    end
    if (fe32) nfe32++;
    if (ov32) nov32++;
    if (fe24) nfe24++;
    if (ov24) nov24++;
  end

  int b32, bf32, bo32, b24, bf24, bo24;

  task automatic snap();
    b32 = n32; bf32 = nfe32; bo32 = nov32;
    b24 = n24; bf24 = nfe24; bo24 = nov24;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit stream: one (ws, sd) pair per BCLK period.
  bit          sws [$];
  bit          ssd [$];
  bit          s_ch [$];
  logic [SW-1:0] s_val [$];
  int          s_len [$];

  function automatic void clear_stream();
    sws.delete(); ssd.delete();
    s_ch.delete(); s_val.delete(); s_len.delete();
  endfunction

  // WS changes on the last bit of the previous slot.
  function automatic void add_slot(bit ch, logic [SW-1:0] val, int len);
    if (sws.size() > 0) sws[sws.size()-1] = ch;
    for (int i = 0; i < len; i++) begin
      sws.push_back(ch);
      if (i < SW) ssd.push_back(val[SW-1-i]);
      else ssd.push_back(1'($urandom_range(0, 1)));
    end
    s_ch.push_back(ch);
    s_val.push_back(val);
    s_len.push_back(len);
  endfunction

  logic [SW:0] exp_q [$];
  int exp_fe;

  // Slot 0 is the preamble whose closing edge acquires lock.
  function automatic void build_exp(int slotw);
    bit fin;
    exp_q.delete();
    exp_fe = 0;
    for (int s = 1; s < s_len.size(); s++) begin
      fin = (s == s_len.size() - 1);
      if (s_len[s] >= SW) exp_q.push_back({s_ch[s], s_val[s]});
      else if (!fin) exp_fe++;
      if (s_len[s] > slotw || (fin && s_len[s] >= slotw)) exp_fe++;
    end
  endfunction

  task automatic play(int from, int to);
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      bclk = 1'b0;
      ws = sws[i];
      sd = ssd[i];
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    bclk = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ready = 1'b1;
    bclk = 1'b0;
    ws = 1'b0;
    sd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_model(string tag, bit do24);
    build_exp(32);
    check($sformatf("%s n32", tag), n32 - b32, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (b32 + i < n32 && b32 + i < 512)
        check($sformatf("%s s32[%0d]", tag, i), cap32[b32+i], exp_q[i]);
    check($sformatf("%s fe32", tag), nfe32 - bf32, exp_fe);
    check($sformatf("%s ov32", tag), nov32 - bo32, 0);
    if (do24) begin
      build_exp(24);
      check($sformatf("%s n24", tag), n24 - b24, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
        if (b24 + i < n24 && b24 + i < 512)
          check($sformatf("%s s24[%0d]", tag, i), cap24[b24+i], exp_q[i]);
      check($sformatf("%s fe24", tag), nfe24 - bf24, exp_fe);
      check($sformatf("%s ov24", tag), nov24 - bo24, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ch;

    repeat (3) @(negedge clk);
    check("rst valid", v32, 0);
    check("rst data", d32, 0);
    check("rst right", r32, 0);
    check("rst locked", l32, 0);
    check("rst ferr", fe32, 0);
    check("rst ovr", ov32, 0);
    check("rst valid24", v24, 0);
    reset = 1'b0;

    // Stereo frame, 32-bit slots.
    clear_stream();
    add_slot(1, SW'($urandom), 4);
    add_slot(0, 24'hA5A5A5, 32);
    add_slot(1, 24'h5A5A5A, 32);
    add_slot(0, SW'($urandom), 8);
    snap();
    play(0, sws.size());
    check_model("stereo", 1'b1);
    check("stereo locked", l32, 1);

    // Backpressure over two slots.
    do_reset();
    clear_stream();
    add_slot(1, SW'($urandom), 4);
    add_slot(0, 24'h123456, 32);
    add_slot(1, 24'h654321, 32);
    add_slot(0, SW'($urandom), 4);
    @(negedge clk);
    ready = 1'b0;
    snap();
    play(0, sws.size());
    check("bp valid held", v32, 1);
    check("bp data held", d32, 24'h123456);
    check("bp right held", r32, 0);
    check("bp overrun", nov32 - bo32, 1);
    check("bp no xfer", n32 - b32, 0);
    check("bp ferr", nfe32 - bf32, 0);
    @(posedge clk);
    #1 ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    repeat (4) @(negedge clk);
    check("bp one xfer", n32 - b32, 1);
    if (b32 < 512) check("bp xfer val", cap32[b32], {1'b0, 24'h123456});
    check("bp valid clr", v32, 0);

    // Short slot then a full slot.
    do_reset();
    clear_stream();
    add_slot(1, SW'($urandom), 4);
    add_slot(0, SW'($urandom), 32);
    add_slot(1, SW'($urandom), 16);
    add_slot(0, 24'h00FF00, 32);
    add_slot(1, SW'($urandom), 8);
    snap();
    play(0, sws.size());
    check_model("short", 1'b1);
    check("short locked", l32, 1);

    // WS stuck for 40 rises, then relock.
    do_reset();
    clear_stream();
    add_slot(1, SW'($urandom), 4);
    add_slot(0, SW'($urandom), 32);
    add_slot(1, SW'($urandom), 40);
    add_slot(0, 24'h800001, 32);
    add_slot(1, SW'($urandom), 8);
    snap();
    play(0, 70);
    check("miss unlocked", l32, 0);
    check("miss ferr mid", nfe32 - bf32, 1);
    play(70, sws.size());
    check_model("miss", 1'b1);
    check("miss relocked", l32, 1);

    // Continuous 24-bit slots.
    do_reset();
    clear_stream();
    add_slot(1, SW'($urandom), 4);
    ch = 1'b0;
    for (int i = 0; i < 10; i++) begin
      add_slot(ch, SW'($urandom), 24);
      ch = ~ch;
    end
    add_slot(ch, SW'($urandom), 4);
    snap();
    play(0, sws.size());
    check_model("slot24", 1'b1);
    check("slot24 locked", l24, 1);

    // Randomized slot lengths, short and long included.
    do_reset();
    clear_stream();
    add_slot(1, SW'($urandom), 3);
    ch = 1'b0;
    for (int i = 0; i < 14; i++) begin
      add_slot(ch, SW'($urandom), $urandom_range(14, 40));
      ch = ~ch;
    end
    snap();
    play(0, sws.size());
    check_model("random", 1'b1);

    // Reset at bit 10 of a slot with a sample held.
    do_reset();
    clear_stream();
    add_slot(1, SW'($urandom), 4);
    add_slot(0, SW'($urandom), 32);
    add_slot(1, SW'($urandom), 32);
    add_slot(0, 24'hABCDEF, 32);
    add_slot(1, SW'($urandom), 4);
    @(negedge clk);
    ready = 1'b0;
    play(0, 46);
    check("mid held", v32, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid rst valid", v32, 0);
    check("mid rst data", d32, 0);
    check("mid rst locked", l32, 0);
    check("mid rst ferr", fe32, 0);
    ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    snap();
    play(46, sws.size());
    check("mid n", n32 - b32, 1);
    if (b32 < 512) check("mid val", cap32[b32], {1'b0, 24'hABCDEF});
    check("mid ferr", nfe32 - bf32, 0);
    check("mid ovr", nov32 - bo32, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
